// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared types and sizes for the register-file writeback scheduler.
package regfile_sched_pkg;

  localparam int REG_SIZE   = 8;
  localparam int VEC_SIZE   = 4;
  localparam int SEL_BITS   = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int DATA_W     = VEC_SIZE * REG_SIZE;
  localparam int NREGS      = 2 ** SEL_BITS;

  // One buffered writeback: destination selector plus the full vector payload.
  typedef struct packed {
    logic [SEL_BITS-1:0] rd;
    logic [DATA_W-1:0]   data;
  } wb_entry_t;

  // Identifies which producer FIFO owns the write port this cycle.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // Selector bit SEL_BITS-2 marks the scalar half of the register space.
  function automatic logic is_scalar(input logic [SEL_BITS-1:0] sel);
    return sel[SEL_BITS-2];
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_fifo.sv
// Small power-of-two FIFO holding pending writebacks for one producer.
module wb_fifo
  import regfile_sched_pkg::*;
#(
  parameter int  DEPTH = FIFO_DEPTH,
  parameter type T     = wb_entry_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  output T     head_o,
  output logic empty_o,
  output logic full_o
);

  localparam int PW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [PW:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]    rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    head_o   = mem_q[rd_ptr_q[PW-1:0]];
  end

  // Storage needs no reset; the pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end
  end

  // Pointer registers; reset discards everything queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Single owner of the register-file write port: buffers ALU and load
// writebacks, round-robins between them and tracks pending destinations.
module regfile_wb_scheduler
  import regfile_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_valid,
  input  logic [SEL_BITS-1:0] iss_rd,
  input  logic [SEL_BITS-1:0] rs1,
  input  logic [SEL_BITS-1:0] rs2,
  output logic                hz_rs1,
  output logic                hz_rs2,
  output logic                hz_rd,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [SEL_BITS-1:0] alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [SEL_BITS-1:0] mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                regWrEnSc,
  output logic                regWrEnVec,
  output logic [SEL_BITS-1:0] regToWrite,
  output logic [DATA_W-1:0]   dataIn_mem,
  output logic [DATA_W-1:0]   dataIn_chip
);

  wb_entry_t         alu_in, mem_in, alu_head, mem_head, win;
  logic              alu_empty, alu_full, mem_empty, mem_full;
  logic              alu_pop, mem_pop, grant_valid;
  src_e              grant_src;
  src_e              rr_q, rr_d;
  logic [NREGS-1:0]  pend_q, pend_d;

  assign alu_in    = '{rd: alu_rd, data: alu_data};
  assign mem_in    = '{rd: mem_rd, data: mem_data};
  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(wb_entry_t)) u_alu_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (alu_valid && alu_ready),
    .push_data_i (alu_in),
    .pop_i       (alu_pop),
    .head_o      (alu_head),
    .empty_o     (alu_empty),
    .full_o      (alu_full)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(wb_entry_t)) u_mem_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (mem_valid && mem_ready),
    .push_data_i (mem_in),
    .pop_i       (mem_pop),
    .head_o      (mem_head),
    .empty_o     (mem_empty),
    .full_o      (mem_full)
  );

  // Arbitrate FIFO heads and decode the granted entry onto the write port.
  always_comb begin
    grant_valid = !alu_empty || !mem_empty;
    rr_d        = rr_q;
    if (!alu_empty && !mem_empty) begin
      grant_src = rr_q;
      rr_d      = (rr_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end else if (!mem_empty) begin
      grant_src = SRC_MEM;
    end else begin
      grant_src = SRC_ALU;
    end
    win         = (grant_src == SRC_ALU) ? alu_head : mem_head;
    alu_pop     = grant_valid && (grant_src == SRC_ALU);
    mem_pop     = grant_valid && (grant_src == SRC_MEM);
    regWrEnSc   = 1'b0;
    regWrEnVec  = 1'b0;
    regToWrite  = '0;
    dataIn_mem  = '0;
    dataIn_chip = '0;
    if (grant_valid) begin
      regWrEnSc   = is_scalar(win.rd);
      regWrEnVec  = !is_scalar(win.rd);
      regToWrite  = win.rd;
      dataIn_mem  = win.data;
      dataIn_chip = win.data;
    end
  end

  // Pending-write bitmap: a reservation in the same cycle as a commit wins.
  always_comb begin
    pend_d = pend_q;
    if (grant_valid) begin
      pend_d[win.rd] = 1'b0;
    end
    if (iss_valid) begin
      pend_d[iss_rd] = 1'b1;
    end
    hz_rs1 = pend_q[rs1];
    hz_rs2 = pend_q[rs2];
    hz_rd  = pend_q[iss_rd];
  end

  // Arbiter pointer and scoreboard state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q   <= SRC_ALU;
      pend_q <= '0;
    end else begin
      rr_q   <= rr_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomised scoreboard bench for the writeback scheduler.
module tb_regfile_wb_scheduler;
  import regfile_sched_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                iss_valid;
  logic [SEL_BITS-1:0] iss_rd, rs1, rs2;
  logic                hz_rs1, hz_rs2, hz_rd;
  logic                alu_valid, alu_ready, mem_valid, mem_ready;
  logic [SEL_BITS-1:0] alu_rd, mem_rd, regToWrite;
  logic [DATA_W-1:0]   alu_data, mem_data, dataIn_mem, dataIn_chip;
  logic                regWrEnSc, regWrEnVec;

  typedef struct {
    logic [SEL_BITS-1:0] rd;
    logic [DATA_W-1:0]   data;
    int                  stamp;
  } exp_t;

  exp_t        qAlu[$];
  exp_t        qMem[$];
  logic [15:0] pendModel = '0;
  bit          rrModel   = 1'b0;
  int          cyc       = 0;
  int          nChecks   = 0;
  int          nFails    = 0;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .iss_valid   (iss_valid),
    .iss_rd      (iss_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .hz_rs1      (hz_rs1),
    .hz_rs2      (hz_rs2),
    .hz_rd       (hz_rd),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .regWrEnSc   (regWrEnSc),
    .regWrEnVec  (regWrEnVec),
    .regToWrite  (regToWrite),
    .dataIn_mem  (dataIn_mem),
    .dataIn_chip (dataIn_chip)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle of inputs just after the edge; accepted pushes become
  // expected writes stamped with the cycle they were offered in.
  task automatic applyStimulus(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                               input logic mv, input logic [3:0] mrd, input logic [31:0] mdat,
                               input logic iv, input logic [3:0] ird,
                               input logic [3:0] r1, input logic [3:0] r2);
    @(posedge clk);
    #1;
    alu_valid = av;  alu_rd = ard;  alu_data = adat;
    mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
    iss_valid = iv;  iss_rd = ird;  rs1 = r1;  rs2 = r2;
    if (reset && av && alu_ready) qAlu.push_back('{rd: ard, data: adat, stamp: cyc});
    if (reset && mv && mem_ready) qMem.push_back('{rd: mrd, data: mdat, stamp: cyc});
  endtask

  task automatic idle(input int n, input logic [3:0] r1);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  // Monitor: each negedge, predict the write that commits at the next edge
  // from the queued pushes and the alternate-on-contention rule, then
  // compare and advance the reference model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        qAlu.delete();
        qMem.delete();
        pendModel = '0;
        rrModel   = 1'b0;
        checkOutput("rst_en_sc", regWrEnSc, 0);
        checkOutput("rst_en_vec", regWrEnVec, 0);
        checkOutput("rst_rd", regToWrite, 0);
        checkOutput("rst_data", dataIn_mem, 0);
        checkOutput("rst_alu_ready", alu_ready, 1);
        checkOutput("rst_mem_ready", mem_ready, 1);
        checkOutput("rst_hz", {hz_rs1, hz_rs2, hz_rd}, 0);
      end else begin
        int  nA, nM;
        bit  aVis, mVis, useMem;
        exp_t e;
        nA = 0;
        nM = 0;
        foreach (qAlu[i]) if (qAlu[i].stamp < cyc) nA++;
        foreach (qMem[i]) if (qMem[i].stamp < cyc) nM++;
        aVis = (nA > 0);
        mVis = (nM > 0);
        checkOutput("alu_ready", alu_ready, (nA < FIFO_DEPTH));
        checkOutput("mem_ready", mem_ready, (nM < FIFO_DEPTH));
        checkOutput("hz_rs1", hz_rs1, pendModel[rs1]);
        checkOutput("hz_rs2", hz_rs2, pendModel[rs2]);
        checkOutput("hz_rd", hz_rd, pendModel[iss_rd]);
        if (aVis || mVis) begin
          if (aVis && mVis) begin
            useMem  = rrModel;
            rrModel = !rrModel;
          end else begin
            useMem = mVis;
          end
          e = useMem ? qMem.pop_front() : qAlu.pop_front();
          checkOutput("wr_rd", regToWrite, e.rd);
          checkOutput("wr_data_mem", dataIn_mem, e.data);
          checkOutput("wr_data_chip", dataIn_chip, e.data);
          checkOutput("wr_en_sc", regWrEnSc, e.rd[2]);
          checkOutput("wr_en_vec", regWrEnVec, !e.rd[2]);
          pendModel[e.rd] = 1'b0;
        end else begin
          checkOutput("idle_en", {regWrEnSc, regWrEnVec}, 0);
          checkOutput("idle_rd", regToWrite, 0);
        end
        if (iss_valid) pendModel[iss_rd] = 1'b1;
      end
      cyc++;
    end
  end

  // Stimulus: directed scenarios first, then a randomised soak.
  initial begin
    reset = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(3, 0);

    // Single scalar ALU write.
    applyStimulus(1, 4'b0100, 32'h01020304, 0, 0, 0, 0, 0, 0, 0);
    idle(3, 0);

    // Simultaneous vector writes from both sources.
    applyStimulus(1, 4'd1, 32'hAAAA0001, 1, 4'd2, 32'hBBBB0002, 0, 0, 0, 0);
    idle(4, 0);

    // Sustained contention fills both FIFOs so ready drops.
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 4'(i), 32'hC000_0000 + i, 1, 4'(i + 8), 32'hD000_0000 + i, 0, 0, 0, 0);
    idle(8, 0);

    // Reservation of r5, its commit, and a re-reservation on the commit edge.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd5, 0);
    idle(3, 5);
    applyStimulus(1, 4'd5, 32'h55555555, 0, 0, 0, 0, 0, 5, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd5, 0);
    idle(3, 5);
    applyStimulus(1, 4'd5, 32'h66666666, 0, 0, 0, 0, 0, 5, 0);
    idle(3, 5);

    // Reset with writes still queued.
    applyStimulus(1, 4'd6, 32'h11111111, 1, 4'd7, 32'h22222222, 1, 4'd6, 6, 7);
    applyStimulus(1, 4'd3, 32'h33333333, 1, 4'd9, 32'h44444444, 0, 0, 6, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 6, 7);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(3, 6);

    // Randomised soak.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 1), 4'($urandom), $urandom,
                    $urandom_range(0, 1), 4'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom), 4'($urandom));
    idle(8, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
